// File: rtl/decoder_sdiv_23s_7s_16_seq.sv
// Multi-cycle signed restoring divider: 23s / 7s -> 16s quotient plus 7s remainder.
// One quotient bit per ce-active cycle; start/done handshake; saturating quotient.
// Optional build macro DECODER_SDIV_ROUND_EN: round half away from zero in the fix-up stage.
module decoder_sdiv_23s_7s_16_seq #(
  parameter int unsigned ID         = 1,
  parameter int unsigned din0_WIDTH = 23,
  parameter int unsigned din1_WIDTH = 7,
  parameter int unsigned dout_WIDTH = 16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  busy,
  output logic                  done,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int unsigned N  = din0_WIDTH;
  localparam int unsigned M  = din1_WIDTH;
  localparam int unsigned Q  = dout_WIDTH;
  localparam int unsigned CW = $clog2(N + 1);

  // Largest positive quotient magnitude and largest negative magnitude (one more).
  localparam logic [N:0] PosMax = (N + 1)'((1 << (Q - 1)) - 1);
  localparam logic [N:0] NegMax = (N + 1)'(1 << (Q - 1));

  typedef enum logic [1:0] {StIdle, StIter, StFix} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  dvd_q;       // dividend magnitude; quotient bits shift in from the LSB
  logic [M:0]    prem_q;      // partial remainder
  logic [M:0]    dmag_q;      // divisor magnitude, M+1 bits so 2^(M-1) is exact
  logic          sign0_q, sign1_q;
  logic [CW-1:0] cnt_q;

  logic          busy_q, done_q, dbz_q, ov_q;
  logic [Q-1:0]  dout_q;
  logic [M-1:0]  rem_q;

  // Operand magnitudes at accept; the N-bit dividend magnitude holds 2^(N-1) exactly.
  logic [N-1:0]  mag0;
  logic [M:0]    mag1;
  always_comb begin
    mag0 = din0[N-1] ? (~din0 + 1'b1) : din0;
    mag1 = {1'b0, (din1[M-1] ? (~din1 + 1'b1) : din1)};
  end

  // One restoring step: shift in the next dividend bit, subtract when it fits.
  logic [M+1:0]  shifted, diff;
  logic          fits;
  always_comb begin
    shifted = {prem_q, dvd_q[N-1]};
    diff    = shifted - {1'b0, dmag_q};
    fits    = ~diff[M+1];
  end

  // Fix-up: optional rounding, sign application, saturation and divide-by-zero override.
  logic [N:0]    qmag;
  logic [Q-1:0]  qlo;
  logic [Q-1:0]  fix_dout;
  logic [M-1:0]  fix_rem;
  logic          fix_ov, fix_dbz, neg;
  always_comb begin
    qmag = {1'b0, dvd_q};
`ifdef DECODER_SDIV_ROUND_EN
    if ({prem_q, 1'b0} >= {1'b0, dmag_q}) begin
      qmag = qmag + 1'b1;
    end
`endif
    qlo      = qmag[Q-1:0];
    neg      = sign0_q ^ sign1_q;
    fix_ov   = 1'b0;
    fix_dbz  = 1'b0;
    fix_rem  = sign0_q ? (~prem_q[M-1:0] + 1'b1) : prem_q[M-1:0];
    fix_dout = neg ? (~qlo + 1'b1) : qlo;
    if (dmag_q == '0) begin
      fix_dbz  = 1'b1;
      fix_rem  = '0;
      fix_dout = sign0_q ? {1'b1, {(Q - 1){1'b0}}} : {1'b0, {(Q - 1){1'b1}}};
    end else if (!neg && (qmag > PosMax)) begin
      fix_ov   = 1'b1;
      fix_dout = {1'b0, {(Q - 1){1'b1}}};
    end else if (neg && (qmag > NegMax)) begin
      fix_ov   = 1'b1;
      fix_dout = {1'b1, {(Q - 1){1'b0}}};
    end
  end

  // Next-state logic for the control FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StIter;
      StIter:  if (cnt_q == CW'(1)) state_d = StFix;
      StFix:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM state register; ce low freezes it.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= StIdle;
    end else if (ce) begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      dvd_q   <= '0;
      prem_q  <= '0;
      dmag_q  <= '0;
      sign0_q <= 1'b0;
      sign1_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else if (ce) begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            dvd_q   <= mag0;
            prem_q  <= '0;
            dmag_q  <= mag1;
            sign0_q <= din0[N-1];
            sign1_q <= din1[M-1];
            cnt_q   <= CW'(N);
            busy_q  <= 1'b1;
          end
        end
        StIter: begin
          dvd_q  <= {dvd_q[N-2:0], fits};
          prem_q <= fits ? diff[M:0] : shifted[M:0];
          cnt_q  <= cnt_q - 1'b1;
        end
        StFix: begin
          dout_q <= fix_dout;
          rem_q  <= fix_rem;
          dbz_q  <= fix_dbz;
          ov_q   <= fix_ov;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: begin
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign dout        = dout_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ov_q;

endmodule

// File: tb/tb_decoder_sdiv_23s_7s_16_seq.sv
// Scoreboard bench for decoder_sdiv_23s_7s_16_seq; expected quotients depend on
// whether DECODER_SDIV_ROUND_EN is defined for the build.
module tb_decoder_sdiv_23s_7s_16_seq;

`ifdef DECODER_SDIV_ROUND_EN
  localparam int R = 1;
`else
  localparam int R = 0;
`endif

  logic        ap_clk = 1'b0;
  logic        ap_rst, ce, start;
  logic [22:0] din0;
  logic [6:0]  din1;
  logic        busy, done, div_by_zero, overflow;
  logic [15:0] dout;
  logic [6:0]  rem;

  decoder_sdiv_23s_7s_16_seq #(
    .ID(1), .din0_WIDTH(23), .din1_WIDTH(7), .dout_WIDTH(16)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .start(start),
    .din0(din0), .din1(din1), .busy(busy), .done(done), .dout(dout),
    .rem(rem), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    int id;
    int q;
    int r;
    bit dbz;
    bit ov;
    int acc_ce;
    int acc_cyc;
    int lat_raw;
  } item_t;

  item_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ce_cyc = 0;
  int next_id = 0;

  always @(posedge ap_clk) begin
    cyc <= cyc + 1;
    if (ce) ce_cyc <= ce_cyc + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: one pop per ce-active done cycle.
  always @(negedge ap_clk) begin
    if (!ap_rst && ce && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        item_t it;
        it = exp_q.pop_front();
        chk($sformatf("dout[%0d]", it.id), int'($signed(dout)), it.q);
        chk($sformatf("rem[%0d]", it.id), int'($signed(rem)), it.r);
        chk($sformatf("div_by_zero[%0d]", it.id), int'(div_by_zero), int'(it.dbz));
        chk($sformatf("overflow[%0d]", it.id), int'(overflow), int'(it.ov));
        chk($sformatf("busy_at_done[%0d]", it.id), int'(busy), 0);
        chk($sformatf("latency_ce[%0d]", it.id), ce_cyc - it.acc_ce, 24);
        chk($sformatf("latency_raw[%0d]", it.id), cyc - it.acc_cyc, it.lat_raw);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge ap_clk); #1;
      n++;
    end
  endtask

  // Drive one start pulse; push the expectation if a result is due.
  task automatic issue(input int a, input int b, input int eq, input int er,
                       input bit edbz, input bit eov, input bit push, input int stall);
    item_t it;
    wait_idle();
    din0  = a[22:0];
    din1  = b[6:0];
    start = 1'b1;
    @(posedge ap_clk); #1;
    start = 1'b0;
    if (push) begin
      it.id      = next_id;
      it.q       = eq;
      it.r       = er;
      it.dbz     = edbz;
      it.ov      = eov;
      it.acc_ce  = ce_cyc;
      it.acc_cyc = cyc;
      it.lat_raw = 24 + stall;
      exp_q.push_back(it);
      next_id++;
    end
    chk("busy_after_accept", int'(busy), 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge ap_clk); #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic run(input int a, input int b, input int eq, input int er,
                     input bit edbz, input bit eov);
    issue(a, b, eq, er, edbz, eov, 1'b1, 0);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    ap_rst = 1'b1; ce = 1'b1; start = 1'b0; din0 = '0; din1 = '0;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_outputs", int'({dout, rem, div_by_zero, overflow}), 0);

    // Basic and sign cases.
    run(1000, 7, 142 + R, 6, 0, 0);
    run(-1000, 7, -(142 + R), -6, 0, 0);
    run(1000, -7, -(142 + R), 6, 0, 0);
    run(-1000, -7, 142 + R, -6, 0, 0);
    run(6400, -64, -100, 0, 0, 0);
    // Saturation boundaries.
    run(-4194304, -1, 32767, 0, 0, 1);
    run(4194303, 1, 32767, 0, 0, 1);
    run(-32768, 1, -32768, 0, 0, 0);
    run(32767, 1, 32767, 0, 0, 0);
    // Divide-by-zero and zero dividend.
    run(5, 0, 32767, 0, 1, 0);
    run(-5, 0, -32768, 0, 1, 0);
    run(0, 0, 32767, 0, 1, 0);
    run(0, 5, 0, 0, 0, 0);
    // Rounding-sensitive vectors.
    run(10, 4, 2 + R, 2, 0, 0);
    run(-10, 4, -(2 + R), -2, 0, 0);
    run(9, 4, 2, 1, 0, 0);
    run(229369, 7, 32767, 0, 0, 0);

    // ce low for 3 cycles mid-iteration stretches latency by 3 raw cycles.
    issue(1000, 7, 142 + R, 6, 0, 0, 1'b1, 3);
    repeat (5) @(posedge ap_clk);
    #1 ce = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1 ce = 1'b1;
    drain();

    // start while busy is ignored; only the first result appears.
    issue(100, 10, 10, 0, 0, 0, 1'b1, 0);
    repeat (5) @(posedge ap_clk);
    #1 din0 = 23'd77; din1 = 7'd3; start = 1'b1;
    @(posedge ap_clk);
    #1 start = 1'b0;
    drain();
    repeat (30) @(posedge ap_clk);
    #1;
    chk("ignored_start_busy", int'(busy), 0);

    // Reset at cycle 10 aborts the operation and clears held results.
    issue(1000, 7, 0, 0, 0, 0, 1'b0, 0);
    repeat (9) @(posedge ap_clk);
    #1 ap_rst = 1'b1;
    @(posedge ap_clk);
    #1 ap_rst = 1'b0;
    chk("abort_dout", int'(dout), 0);
    chk("abort_busy", int'(busy), 0);
    repeat (30) @(posedge ap_clk);
    #1;
    chk("abort_outputs", int'({done, dout, rem, div_by_zero, overflow}), 0);

    // Back-to-back: start raised during the done cycle.
    issue(-1000, 7, -(142 + R), -6, 0, 0, 1'b1, 0);
    begin
      int n = 0;
      while (!done && n < 100) begin
        @(posedge ap_clk); #1;
        n++;
      end
      chk("b2b_done_seen", int'(done), 1);
    end
    din0 = 23'd6400; din1 = 7'd64;
    start = 1'b1;
    @(posedge ap_clk); #1;
    start = 1'b0;
    begin
      item_t it;
      it.id = next_id; it.q = -100; it.r = 0; it.dbz = 0; it.ov = 0;
      it.acc_ce = ce_cyc; it.acc_cyc = cyc; it.lat_raw = 24;
      exp_q.push_back(it);
      next_id++;
    end
    chk("b2b_busy", int'(busy), 1);
    drain();
    repeat (5) @(posedge ap_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_sdiv_23s_7s_16_seq.md
Name: decoder_sdiv_23s_7s_16_seq

Overview:
Multi-cycle signed restoring divider. It is the inverse companion to the decoder's 16s x 7s -> 23s multiplier datapath. It rescales 23-bit accumulated products back to the 16-bit activation width by a 7-bit signed divisor, for example a per-layer scale or pooling count. It sits in the decoder IP datapath behind the MAC stage, is driven by an HLS-style start/done handshake, and issues one quotient bit per cycle.

Parameters:
ID, 1, instance identifier; no functional effect.
din0_WIDTH, 23, signed dividend width (N).
din1_WIDTH, 7, signed divisor width (M).
dout_WIDTH, 16, signed quotient width (Q).

Ports:
ap_clk  in  1  clock; all logic rising-edge.
ap_rst  in  1  synchronous reset, active-high.
ce  in  1  clock enable; low freezes all state and outputs.
start  in  1  request; sampled only in IDLE with ce=1.
din0  in  N  signed dividend; sampled with start.
din1  in  M  signed divisor; sampled with start.
busy  out  1  high from accept until done.
done  out  1  one-cycle pulse; result valid.
dout  out  Q  signed quotient; held until next done.
rem  out  M  signed remainder; held until next done.
div_by_zero  out  1  status for current result; held.
overflow  out  1  quotient saturated; held.

Behaviour:
- Reset: ap_rst=1 on an edge sets state to IDLE and clears busy, done, dout, rem, div_by_zero and overflow to 0. Reset mid-operation aborts the operation; no done is produced.
- States:
  - IDLE: on start and ce at edge T, register |din0|, |din1| and the sign bits; set iteration count to N; busy=1; go to ITER.
  - ITER: each ce edge, shift the partial remainder left by one and bring in the next dividend MSB. If the partial remainder >= |divisor|, subtract and set the quotient bit to 1. After N iterations (edge T+N), go to FIX.
  - FIX: at edge T+N+1, apply signs, saturate, and register the outputs. done=1, busy=0, go to IDLE.
- Latency: done is high in the cycle after edge T+N+1, i.e. 24 ce-active edges for the defaults. ce=0 cycles extend latency one-for-one.
- done is high exactly one ce-active cycle. If ce=0 in the done cycle, done holds until the next ce edge.
- start while busy is ignored, with no queueing. start in the same cycle done is high is accepted (back-to-back issue).
- Arithmetic:
  - Quotient truncates toward zero.
  - Quotient sign = sign(din0) XOR sign(din1).
  - Remainder sign follows the dividend; |rem| < |din1|.
  - Magnitudes use N+1 and M+1 bits internally, so -2^(N-1) and -2^(M-1) (-64) are exact.
- Saturation: if the true quotient is outside [-2^(Q-1), 2^(Q-1)-1], dout clamps to the nearest bound and overflow=1. rem remains the true remainder.
- Divide-by-zero (din1=0): the operation still takes full latency. dout=+32767 if din0>=0, else -32768. rem=0, div_by_zero=1, overflow=0.
- Zero dividend: dout=0, rem=0, no flags.
- No X propagation: unused datapath registers are cleared on accept.

Optional Feature:
DECODER_SDIV_ROUND_EN.
- Defined: FIX rounds half away from zero. If 2*|partial rem| >= |divisor|, the quotient magnitude increments before sign and saturation are applied; overflow is evaluated after rounding. rem still reports the truncation remainder. Latency is unchanged.
- Undefined: truncation only; the rounding comparator is not synthesized.

Test Plan:
1. start with din0=1000, din1=7 at edge T -> busy edges T..T+24, done pulse after edge T+24, dout=142, rem=6, flags 0.
2. Sign cases:
   - -1000/7 -> dout=-142, rem=-6.
   - 1000/-7 -> dout=-142, rem=6.
   - -1000/-7 -> dout=142, rem=-6.
   - -64 divisor: 6400/-64 -> dout=-100, rem=0.
3. Overflow:
   - -4194304/-1 -> dout=32767, overflow=1.
   - 4194303/1 -> dout=32767, overflow=1.
   - -32768/1 -> dout=-32768, overflow=0.
   - 32767/1 -> overflow=0.
4. Divide-by-zero:
   - 5/0 -> dout=32767, rem=0, div_by_zero=1, same latency.
   - -5/0 -> dout=-32768.
   - 0/0 -> dout=32767.
5. Control:
   - ce=0 for 3 cycles mid-ITER -> done 3 cycles later, result unchanged.
   - start pulsed while busy -> ignored.
   - ap_rst at cycle 10 of an operation -> no done, all outputs 0.
   - start in the done cycle -> second result after 24 more edges.
6. With DECODER_SDIV_ROUND_EN:
   - 10/4 -> 3.
   - -10/4 -> -3.
   - 9/4 -> 2.
   - 32767*7/7 path (229369/7) -> 32767, no overflow.
   - Without the macro: 10/4 -> 2, -10/4 -> -2.
